vce2_vseq: RTL and testbench

- Element sequencer: the initiator that drives the vector AGU's VRF-side control (load/get/incr/ready) and consumes its generated addresses.
- For each element of a vector op it reads an rs1 word and an rs2 word from data memory, hands the pair to the vector ALU lane, then writes the result word to rd.
- Sits between the decode/issue stage, vce2_agu, the data-memory (OBI-style req/gnt/rvalid) port and the vector ALU.

---
 rtl/vce2_pkg.sv | 27 ++
 rtl/vce2_vseq.sv | 229 ++++++++++++++++++++++
 tb/tb_vce2_vseq.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vce2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vce2_pkg
//  Description : Shared types and constants for the vce2 element sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package vce2_pkg;

    // Element-sequencer states, one per phase of an element's read/exec/write
    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        LOAD   = 4'd1,
        REQ_A  = 4'd2,
        WAIT_A = 4'd3,
        REQ_B  = 4'd4,
        WAIT_B = 4'd5,
        EXEC   = 4'd6,
        REQ_W  = 4'd7,
        WAIT_W = 4'd8,
        DONE   = 4'd9
    } vseq_state_e;

    // Every data-memory access is a full 32-bit word
    localparam logic [3:0] c_BE_FULL = 4'hF;

endpackage
`default_nettype wire

// File: rtl/vce2_vseq.sv
`default_nettype none
// ============================================================================
//  Module      : vce2_vseq
//  Description : Vector element sequencer. For each element it reads rs1 and
//                rs2 words via the AGU-generated addresses, presents them to
//                the vector ALU, and writes the result back to rd.
//                Optional macro VCE2_VSEQ_SCALAR_OPB_EN adds a latched scalar
//                operand B that replaces the rs2 read when enabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module vce2_vseq
    import vce2_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned VL_WIDTH   = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [VL_WIDTH-1:0]   vl_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  agu_load_o,
    input  logic                  agu_ready_i,
    output logic                  agu_get_rs1_o,
    output logic                  agu_get_rs2_o,
    output logic                  agu_get_rd_o,
    output logic                  agu_incr_o,
    input  logic [ADDR_WIDTH-1:0] agu_addr_i,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    input  logic                  data_rvalid_i,
    output logic [ADDR_WIDTH-1:0] data_addr_o,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [31:0]           data_wdata_o,
    input  logic [31:0]           data_rdata_i,
    output logic [31:0]           alu_op_a_o,
    output logic [31:0]           alu_op_b_o,
    output logic                  alu_valid_o,
    input  logic [31:0]           alu_result_i
`ifdef VCE2_VSEQ_SCALAR_OPB_EN
    ,
    input  logic                  scalar_en_i,
    input  logic [31:0]           scalar_i
`endif
);

    vseq_state_e         r_state;
    vseq_state_e         w_state_next;
    logic [VL_WIDTH-1:0] r_vl;
    logic [VL_WIDTH-1:0] r_cnt;
    logic [VL_WIDTH-1:0] w_cnt_inc;
    logic                r_load_sent;
    logic [31:0]         r_op_a;
    logic [31:0]         r_op_b;
    logic [31:0]         r_wdata;
    logic                w_scalar_mode;

    logic w_busy, w_done, w_load, w_get_rs1, w_get_rs2, w_get_rd, w_incr;
    logic w_req, w_we, w_alu_valid;

`ifdef VCE2_VSEQ_SCALAR_OPB_EN
    logic        r_scalar_en;
    logic [31:0] r_scalar;
    assign w_scalar_mode = r_scalar_en;
`else
    assign w_scalar_mode = 1'b0;
`endif

    assign w_cnt_inc = r_cnt + VL_WIDTH'(1);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control outputs; late-arriving rvalid in a REQ state is ignored
    always_comb begin
        w_state_next = r_state;
        w_busy       = (r_state != IDLE);
        w_done       = 1'b0;
        w_load       = 1'b0;
        w_get_rs1    = 1'b0;
        w_get_rs2    = 1'b0;
        w_get_rd     = 1'b0;
        w_incr       = 1'b0;
        w_req        = 1'b0;
        w_we         = 1'b0;
        w_alu_valid  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start_i) w_state_next = LOAD;
            end
            LOAD: begin
                w_load = !r_load_sent;
                if (agu_ready_i) begin
                    w_state_next = (r_vl == '0) ? DONE : REQ_A;
                end
            end
            REQ_A: begin
                w_get_rs1 = 1'b1;
                w_req     = 1'b1;
                if (data_gnt_i) begin
                    w_incr       = 1'b1;
                    w_state_next = WAIT_A;
                end
            end
            WAIT_A: begin
                if (data_rvalid_i) begin
                    w_state_next = w_scalar_mode ? EXEC : REQ_B;
                end
            end
            REQ_B: begin
                w_get_rs2 = 1'b1;
                w_req     = 1'b1;
                if (data_gnt_i) begin
                    w_incr       = 1'b1;
                    w_state_next = WAIT_B;
                end
            end
            WAIT_B: begin
                if (data_rvalid_i) w_state_next = EXEC;
            end
            EXEC: begin
                w_alu_valid  = 1'b1;
                w_state_next = REQ_W;
            end
            REQ_W: begin
                w_get_rd = 1'b1;
                w_req    = 1'b1;
                w_we     = 1'b1;
                if (data_gnt_i) begin
                    w_incr       = 1'b1;
                    w_state_next = WAIT_W;
                end
            end
            WAIT_W: begin
                if (data_rvalid_i) begin
                    w_state_next = (w_cnt_inc == r_vl) ? DONE : REQ_A;
                end
            end
            DONE: begin
                w_done       = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Operation context, element counter and operand/result registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vl        <= '0;
            r_cnt       <= '0;
            r_load_sent <= 1'b0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_wdata     <= '0;
`ifdef VCE2_VSEQ_SCALAR_OPB_EN
            r_scalar_en <= 1'b0;
            r_scalar    <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_vl        <= vl_i;
                        r_cnt       <= '0;
                        r_load_sent <= 1'b0;
`ifdef VCE2_VSEQ_SCALAR_OPB_EN
                        r_scalar_en <= scalar_en_i;
                        r_scalar    <= scalar_i;
`endif
                    end
                end
                LOAD: begin
                    r_load_sent <= 1'b1;
                end
                WAIT_A: begin
                    if (data_rvalid_i) begin
                        r_op_a <= data_rdata_i;
`ifdef VCE2_VSEQ_SCALAR_OPB_EN
                        if (r_scalar_en) r_op_b <= r_scalar;
`endif
                    end
                end
                WAIT_B: begin
                    if (data_rvalid_i) r_op_b <= data_rdata_i;
                end
                EXEC: begin
                    r_wdata <= alu_result_i;
                end
                WAIT_W: begin
                    if (data_rvalid_i) r_cnt <= w_cnt_inc;
                end
                DONE: begin
                    r_cnt <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy_o        = w_busy;
    assign done_o        = w_done;
    assign agu_load_o    = w_load;
    assign agu_get_rs1_o = w_get_rs1;
    assign agu_get_rs2_o = w_get_rs2;
    assign agu_get_rd_o  = w_get_rd;
    assign agu_incr_o    = w_incr;
    assign data_req_o    = w_req;
    assign data_we_o     = w_we;
    assign data_addr_o   = agu_addr_i;
    assign data_be_o     = w_req ? c_BE_FULL : 4'h0;
    assign data_wdata_o  = r_wdata;
    assign alu_op_a_o    = r_op_a;
    assign alu_op_b_o    = r_op_b;
    assign alu_valid_o   = w_alu_valid;

endmodule
`default_nettype wire

// File: tb/tb_vce2_vseq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vce2_vseq
//  Description : Self-checking bench for vce2_vseq with an AGU model, a
//                randomised-latency data memory and a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vce2_vseq;

    localparam logic [31:0] RS1_BASE = 32'h0000_0100;
    localparam logic [31:0] RS2_BASE = 32'h0000_0200;
    localparam logic [31:0] RD_BASE  = 32'h0000_0300;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [7:0]  vl_i = 8'd0;
    logic        busy_o, done_o, agu_load_o, agu_ready_i;
    logic        agu_get_rs1_o, agu_get_rs2_o, agu_get_rd_o, agu_incr_o;
    logic [31:0] agu_addr_i;
    logic        data_req_o, data_gnt_i, data_rvalid_i, data_we_o;
    logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
    logic [3:0]  data_be_o;
    logic [31:0] alu_op_a_o, alu_op_b_o, alu_result_i;
    logic        alu_valid_o;
    logic        scalar_en_i = 1'b0;
    logic [31:0] scalar_i = 32'd0;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    // Vector ALU lane: add
    assign alu_result_i = alu_op_a_o + alu_op_b_o;

    vce2_vseq dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .vl_i(vl_i),
        .busy_o(busy_o), .done_o(done_o), .agu_load_o(agu_load_o),
        .agu_ready_i(agu_ready_i), .agu_get_rs1_o(agu_get_rs1_o),
        .agu_get_rs2_o(agu_get_rs2_o), .agu_get_rd_o(agu_get_rd_o),
        .agu_incr_o(agu_incr_o), .agu_addr_i(agu_addr_i),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
        .data_rvalid_i(data_rvalid_i), .data_addr_o(data_addr_o),
        .data_we_o(data_we_o), .data_be_o(data_be_o),
        .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i),
        .alu_op_a_o(alu_op_a_o), .alu_op_b_o(alu_op_b_o),
        .alu_valid_o(alu_valid_o), .alu_result_i(alu_result_i)
`ifdef VCE2_VSEQ_SCALAR_OPB_EN
        , .scalar_en_i(scalar_en_i), .scalar_i(scalar_i)
`endif
    );

    logic [141:0] all_out;
    assign all_out = {busy_o, done_o, agu_load_o, agu_get_rs1_o, agu_get_rs2_o,
                      agu_get_rd_o, agu_incr_o, data_req_o, data_we_o, data_be_o,
                      data_wdata_o, data_addr_o, alu_op_a_o, alu_op_b_o, alu_valid_o};

    // ---------------- AGU model: three word pointers ----------------
    logic [31:0] p_rs1, p_rs2, p_rd;
    always_comb begin
        agu_addr_i = 32'd0;
        if (agu_get_rs1_o)      agu_addr_i = p_rs1;
        else if (agu_get_rs2_o) agu_addr_i = p_rs2;
        else if (agu_get_rd_o)  agu_addr_i = p_rd;
    end

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni || agu_load_o) begin
            p_rs1 <= RS1_BASE;
            p_rs2 <= RS2_BASE;
            p_rd  <= RD_BASE;
        end else if (agu_incr_o) begin
            if (agu_get_rs1_o) p_rs1 <= p_rs1 + 32'd4;
            if (agu_get_rs2_o) p_rs2 <= p_rs2 + 32'd4;
            if (agu_get_rd_o)  p_rd  <= p_rd + 32'd4;
        end
    end

    // ---------------- Event counters ----------------
    int cyc = 0, incr_cnt = 0, valid_cnt = 0, load_cnt = 0;
    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (rst_ni) begin
            if (agu_incr_o)  incr_cnt  <= incr_cnt + 1;
            if (alu_valid_o) valid_cnt <= valid_cnt + 1;
            if (agu_load_o)  load_cnt  <= load_cnt + 1;
        end
    end

    // ---------------- Data memory + AGU ready responder ----------------
    logic [31:0] mem [0:1023];
    int gnt_max = 0, rv_min = 1, rv_max = 1;
    int viol = 0, gnt_cnt = 0;
    bit pend = 0, in_req = 0;
    int rv_cnt = 0, gw = 0, ld_cnt = 0;
    logic [31:0] cap_addr, cap_wdata, pend_addr;
    logic        cap_we, pend_we;
    logic [2:0]  cap_sel;
    logic [31:0] q_addr[$];
    logic        q_we[$];
    logic [31:0] q_data[$];

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            data_gnt_i = 1'b0; data_rvalid_i = 1'b0; agu_ready_i = 1'b0;
            data_rdata_i = 32'd0; pend = 0; in_req = 0; ld_cnt = 0;
        end else begin
            data_gnt_i = 1'b0; data_rvalid_i = 1'b0; agu_ready_i = 1'b0;
            if (ld_cnt > 0) begin
                ld_cnt = ld_cnt - 1;
                if (ld_cnt == 0) agu_ready_i = 1'b1;
            end
            if (agu_load_o) ld_cnt = 2;
            if (data_req_o ? (data_be_o !== 4'hF) : (data_be_o !== 4'h0)) viol++;
            if (pend) begin
                if (data_req_o) viol++;
                if (rv_cnt == 0) begin
                    data_rvalid_i = 1'b1;
                    data_rdata_i  = pend_we ? $urandom : mem[pend_addr[11:2]];
                    pend = 0;
                end else begin
                    rv_cnt = rv_cnt - 1;
                end
            end else if (data_req_o) begin
                if (!in_req) begin
                    in_req = 1; gw = $urandom_range(gnt_max, 0);
                    cap_addr = data_addr_o; cap_we = data_we_o; cap_wdata = data_wdata_o;
                    cap_sel = {agu_get_rs1_o, agu_get_rs2_o, agu_get_rd_o};
                end else if (data_addr_o !== cap_addr || data_we_o !== cap_we ||
                             data_wdata_o !== cap_wdata ||
                             {agu_get_rs1_o, agu_get_rs2_o, agu_get_rd_o} !== cap_sel) begin
                    viol++;
                end
                if (gw == 0) begin
                    data_gnt_i = 1'b1; in_req = 0; pend = 1;
                    rv_cnt = $urandom_range(rv_max, rv_min) - 1;
                    pend_addr = data_addr_o; pend_we = data_we_o;
                    q_addr.push_back(data_addr_o); q_we.push_back(data_we_o);
                    q_data.push_back(data_wdata_o);
                    gnt_cnt++;
                end else begin
                    gw = gw - 1;
                end
            end
        end
    end

    // ---------------- Reference model ----------------
    logic [31:0] a_vals [0:7];
    logic [31:0] b_vals [0:7];
    logic [31:0] exp_addr[$];
    logic        exp_we[$];
    logic [31:0] exp_data[$];

    // Expected memory traffic for one vector op: per element rs1 read,
    // rs2 read (unless scalar operand), then rd write of the sum.
    function automatic void build_model(input int vl, input bit scalar, input logic [31:0] s);
        exp_addr.delete(); exp_we.delete(); exp_data.delete();
        for (int i = 0; i < vl; i++) begin
            exp_addr.push_back(RS1_BASE + 32'(4 * i)); exp_we.push_back(1'b0); exp_data.push_back(32'd0);
            if (!scalar) begin
                exp_addr.push_back(RS2_BASE + 32'(4 * i)); exp_we.push_back(1'b0); exp_data.push_back(32'd0);
            end
            exp_addr.push_back(RD_BASE + 32'(4 * i)); exp_we.push_back(1'b1);
            exp_data.push_back(a_vals[i] + (scalar ? s : b_vals[i]));
        end
    endfunction

    task automatic load_mem();
        for (int i = 0; i < 8; i++) begin
            mem[int'(RS1_BASE >> 2) + i] = a_vals[i];
            mem[int'(RS2_BASE >> 2) + i] = b_vals[i];
        end
    endtask

    task automatic rand_vals();
        for (int i = 0; i < 8; i++) begin
            a_vals[i] = $urandom;
            b_vals[i] = $urandom;
        end
    endtask

    // Issue one op and wait (bounded) for done_o; optionally hammer start_i while busy
    task automatic run_op(input int vl, input bit noisy, output int lat, output bit gap, output bit tmo);
        int t0;
        @(negedge clk_i);
        start_i = 1'b1; vl_i = 8'(vl); t0 = cyc;
        gap = 0; tmo = 1; lat = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_i);
            if (done_o) begin
                start_i = 1'b0; tmo = 0; lat = cyc - t0;
                break;
            end
            if (!busy_o) gap = 1;
            start_i = noisy ? 1'($urandom) : 1'b0;
            vl_i = 8'($urandom);
        end
        start_i = 1'b0;
    endtask

    // ---------------- Tests ----------------
    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL reset_outputs got %h required 0", all_out);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL idle_outputs got %h required 0", all_out);
        end
    endtask

    task automatic test_basic();
        int lat, n0, i0; bit gap, tmo;
        a_vals[0] = 1;  a_vals[1] = 2;  a_vals[2] = 3;
        b_vals[0] = 10; b_vals[1] = 20; b_vals[2] = 30;
        load_mem(); build_model(3, 0, 32'd0);
        gnt_max = 0; rv_min = 1; rv_max = 1;
        n0 = q_addr.size(); i0 = incr_cnt;
        run_op(3, 0, lat, gap, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL basic_timeout got timeout required done"); end
        checks++; if (lat != 25) begin errors++; $display("FAIL basic_latency got %0d required 25", lat); end
        checks++; if (gap) begin errors++; $display("FAIL basic_busy got busy low required high"); end
        checks++; if (q_addr.size() - n0 != exp_addr.size()) begin
            errors++; $display("FAIL basic_txn_count got %0d required %0d", q_addr.size() - n0, exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && n0 + i < q_addr.size(); i++) begin
            checks++;
            if (q_addr[n0+i] !== exp_addr[i] || q_we[n0+i] !== exp_we[i] || (exp_we[i] && q_data[n0+i] !== exp_data[i])) begin
                errors++; $display("FAIL basic_txn[%0d] got a=%h we=%b d=%h required a=%h we=%b d=%h", i,
                                   q_addr[n0+i], q_we[n0+i], q_data[n0+i], exp_addr[i], exp_we[i], exp_data[i]);
            end
        end
        checks++; if (incr_cnt - i0 != 9) begin errors++; $display("FAIL basic_incr got %0d required 9", incr_cnt - i0); end
        @(negedge clk_i);
        checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++; $display("FAIL basic_after got busy=%b done=%b required 0 0", busy_o, done_o);
        end
    endtask

    task automatic test_vl_zero();
        int lat, n0, l0; bit gap, tmo;
        n0 = q_addr.size(); l0 = load_cnt;
        run_op(0, 0, lat, gap, tmo);
        checks++; if (tmo || lat != 4) begin errors++; $display("FAIL vl0_latency got %0d (timeout=%b) required 4", lat, tmo); end
        checks++; if (load_cnt - l0 != 1) begin errors++; $display("FAIL vl0_load got %0d required 1", load_cnt - l0); end
        checks++; if (q_addr.size() != n0) begin errors++; $display("FAIL vl0_txn got %0d required 0", q_addr.size() - n0); end
        @(negedge clk_i);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL vl0_busy got %b required 0", busy_o); end
    endtask

    task automatic test_random_latency();
        int lat, n0, i0, g0, v0, a0, l0, vl; bit gap, tmo;
        gnt_max = 4; rv_min = 1; rv_max = 3;
        for (int r = 0; r < 3; r++) begin
            vl = (r == 0) ? 5 : $urandom_range(7, 1);
            rand_vals(); load_mem(); build_model(vl, 0, 32'd0);
            n0 = q_addr.size(); i0 = incr_cnt; g0 = gnt_cnt; v0 = viol; a0 = valid_cnt; l0 = load_cnt;
            run_op(vl, 0, lat, gap, tmo);
            checks++; if (tmo || gap) begin errors++; $display("FAIL rand_done got timeout=%b busygap=%b required 0 0", tmo, gap); end
            checks++; if (q_addr.size() - n0 != 3 * vl) begin
                errors++; $display("FAIL rand_txn_count got %0d required %0d", q_addr.size() - n0, 3 * vl);
            end
            for (int i = 0; i < exp_addr.size() && n0 + i < q_addr.size(); i++) begin
                checks++;
                if (q_addr[n0+i] !== exp_addr[i] || q_we[n0+i] !== exp_we[i] || (exp_we[i] && q_data[n0+i] !== exp_data[i])) begin
                    errors++; $display("FAIL rand_txn[%0d] got a=%h we=%b d=%h required a=%h we=%b d=%h", i,
                                       q_addr[n0+i], q_we[n0+i], q_data[n0+i], exp_addr[i], exp_we[i], exp_data[i]);
                end
            end
            checks++; if (viol != v0) begin errors++; $display("FAIL rand_stable got %0d violations required 0", viol - v0); end
            checks++; if (incr_cnt - i0 != 3 * vl || gnt_cnt - g0 != 3 * vl) begin
                errors++; $display("FAIL rand_incr got incr=%0d gnt=%0d required %0d", incr_cnt - i0, gnt_cnt - g0, 3 * vl);
            end
            checks++; if (valid_cnt - a0 != vl || load_cnt - l0 != 1) begin
                errors++; $display("FAIL rand_valid got valid=%0d load=%0d required %0d 1", valid_cnt - a0, load_cnt - l0, vl);
            end
        end
        gnt_max = 0; rv_min = 1; rv_max = 1;
    endtask

    task automatic test_abort();
        int lat, n0; bit gap, tmo;
        gnt_max = 0; rv_min = 3; rv_max = 3;
        rand_vals(); load_mem();
        n0 = q_addr.size();
        @(negedge clk_i); start_i = 1'b1; vl_i = 8'd3;
        @(negedge clk_i); start_i = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (q_addr.size() >= n0 + 5) break;
            @(negedge clk_i);
        end
        checks++;
        if (q_addr.size() < n0 + 5 || q_addr[n0+4] !== RS2_BASE + 32'd4) begin
            errors++; $display("FAIL abort_reach got %0d txns required rs2 read of element 2", q_addr.size() - n0);
        end
        @(posedge clk_i); #2;
        rst_ni = 1'b0; #1;
        checks++;
        if (all_out !== '0) begin errors++; $display("FAIL abort_outputs got %h required 0", all_out); end
        @(negedge clk_i); @(negedge clk_i);
        rst_ni = 1'b1; rv_min = 1; rv_max = 1;
        rand_vals(); load_mem(); build_model(1, 0, 32'd0);
        n0 = q_addr.size();
        run_op(1, 0, lat, gap, tmo);
        checks++; if (tmo || lat != 11) begin errors++; $display("FAIL abort_restart_latency got %0d (timeout=%b) required 11", lat, tmo); end
        checks++;
        if (q_addr.size() - n0 != 3 || q_addr[n0+2] !== RD_BASE || q_data[n0+2] !== exp_data[2]) begin
            errors++; $display("FAIL abort_restart_write got %0d txns required 3 with rd=%h", q_addr.size() - n0, exp_data[2]);
        end
    endtask

    task automatic test_start_ignored();
        int lat, n0; bit gap, tmo;
        rand_vals(); load_mem(); build_model(2, 0, 32'd0);
        n0 = q_addr.size();
        run_op(2, 1, lat, gap, tmo);
        checks++; if (tmo || lat != 18) begin errors++; $display("FAIL ignore_latency got %0d (timeout=%b) required 18", lat, tmo); end
        checks++;
        if (q_addr.size() - n0 != 6 || q_data[n0+2] !== exp_data[2] || q_data[n0+5] !== exp_data[5]) begin
            errors++; $display("FAIL ignore_writes got %0d txns required 6 with %h %h", q_addr.size() - n0, exp_data[2], exp_data[5]);
        end
        repeat (6) @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0 || q_addr.size() - n0 != 6) begin
            errors++; $display("FAIL ignore_quiet got busy=%b txns=%0d required 0 6", busy_o, q_addr.size() - n0);
        end
    endtask

`ifdef VCE2_VSEQ_SCALAR_OPB_EN
    task automatic test_scalar();
        int lat, n0; bit gap, tmo;
        a_vals[0] = 5; a_vals[1] = 6;
        load_mem(); build_model(2, 1, 32'd7);
        scalar_en_i = 1'b1; scalar_i = 32'd7;
        n0 = q_addr.size();
        run_op(2, 0, lat, gap, tmo);
        scalar_en_i = 1'b0;
        checks++; if (tmo || lat != 14) begin errors++; $display("FAIL scalar_latency got %0d (timeout=%b) required 14", lat, tmo); end
        checks++; if (q_addr.size() - n0 != exp_addr.size()) begin
            errors++; $display("FAIL scalar_txn_count got %0d required %0d", q_addr.size() - n0, exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && n0 + i < q_addr.size(); i++) begin
            checks++;
            if (q_addr[n0+i] !== exp_addr[i] || q_we[n0+i] !== exp_we[i] || (exp_we[i] && q_data[n0+i] !== exp_data[i])) begin
                errors++; $display("FAIL scalar_txn[%0d] got a=%h d=%h required a=%h d=%h", i,
                                   q_addr[n0+i], q_data[n0+i], exp_addr[i], exp_data[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_vl_zero();
        test_random_latency();
        test_abort();
        test_start_ignored();
`ifdef VCE2_VSEQ_SCALAR_OPB_EN
        test_scalar();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
